systolic_deskew_collector: RTL and testbench

- Receive end of the skewed-operand stream used around the 5x5 Systolic_Array.
- The feeder launches lane k of each row k cycles after lane 0. This block captures the per-lane outputs (A*_out or B*_out lanes), removes the staircase skew and re-forms whole aligned rows.
- Aligned rows are buffered in a small FIFO and handed downstream over a valid/ready interface, with sticky error flags for skew violations and overflow.
- One instance serves one edge of the array (row edge or column edge).

---
 rtl/systolic_deskew_collector_if.sv | 27 ++
 rtl/systolic_deskew_collector.sv | 121 ++++++++++++
 tb/tb_systolic_deskew_collector.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_deskew_collector_if.sv
// Handshake bundle for the deskew collector.
//   in_data   : L lanes of N bits, lane k at [k*N +: N], skewed by k cycles
//   in_valid  : per-lane valid, staircase-skewed like the data
//   out_data  : aligned row, same lane packing
//   out_valid : a row is available on out_data
//   out_ready : downstream accepts the row this cycle
// The master modport belongs to the feeder/consumer side; the slave modport belongs to the collector.
interface systolic_deskew_collector_if #(
  parameter int N = 32,
  parameter int L = 5
);
  logic [L*N-1:0] in_data;
  logic [L-1:0]   in_valid;
  logic [L*N-1:0] out_data;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/systolic_deskew_collector.sv
// Removes the staircase skew from one edge of the systolic array and
// re-forms whole rows. The aligned rows go into a small FIFO that is drained
// over a valid/ready handshake.
//   clk      : system clock, rising edge
//   clr      : synchronous active-high reset, overrides everything
//   bus      : slave side of the lane/handshake interface
//   rows_out : rows accepted downstream, wraps modulo 2^CW
//   skew_err : sticky, the aligned lanes disagreed on valid
//   ovf_err  : sticky, a complete row was dropped because the FIFO was full
//   empty    : the FIFO holds no rows
//   full     : the FIFO holds DEPTH rows
module systolic_deskew_collector #(
  parameter int N     = 32,
  parameter int L     = 5,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                           clk,
  input  logic                           clr,
  systolic_deskew_collector_if.slave     bus,
  output logic [CW-1:0]                  rows_out,
  output logic                           skew_err,
  output logic                           ovf_err,
  output logic                           empty,
  output logic                           full
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [N-1:0]   al_data [L];
  logic [L-1:0]   al_valid;
  logic [L*N-1:0] al_row;

  // Lane k is delayed by L-1-k stages so that every lane of a row lines up
  // with the undelayed last lane.
  for (genvar k = 0; k < L; k++) begin : g_lane
    localparam int D = L - 1 - k;
    if (D == 0) begin : g_direct
      assign al_data[k]  = bus.in_data[k*N +: N];
      assign al_valid[k] = bus.in_valid[k];
    end else begin : g_dly
      logic [N-1:0] d_q [D];
      logic [D-1:0] v_q;
      always_ff @(posedge clk) begin
        if (clr) begin
          for (int s = 0; s < D; s++) d_q[s] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= bus.in_data[k*N +: N];
          v_q[0] <= bus.in_valid[k];
          for (int s = 1; s < D; s++) begin
            d_q[s] <= d_q[s-1];
            v_q[s] <= v_q[s-1];
          end
        end
      end
      assign al_data[k]  = d_q[D-1];
      assign al_valid[k] = v_q[D-1];
    end
  end

  always_comb begin
    al_row = '0;
    for (int k = 0; k < L; k++) al_row[k*N +: N] = al_data[k];
  end

  logic [L*N-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic           empty_q, full_q;
  logic [CW-1:0]  rows_q;
  logic           skew_q, ovf_q;

  logic row_all, row_any, pop, push, drop;

  assign row_all = &al_valid;
  assign row_any = |al_valid;
  assign pop     = ~empty_q & bus.out_ready;
  // A full FIFO still takes a row when the head leaves in the same cycle.
  assign push    = row_all & (~full_q | pop);
  assign drop    = row_all & full_q & ~pop;
  assign cnt_d   = cnt_q + CNTW'(push) - CNTW'(pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      rows_q  <= '0;
      skew_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= al_row;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q   <= rd_q + AW'(1);
        rows_q <= rows_q + CW'(1);
      end
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNTW'(DEPTH));
      if (row_any & ~row_all) skew_q <= 1'b1;
      if (drop)               ovf_q  <= 1'b1;
    end
  end

  assign bus.out_valid = ~empty_q;
  assign bus.out_data  = mem_q[rd_q];
  assign rows_out      = rows_q;
  assign skew_err      = skew_q;
  assign ovf_err       = ovf_q;
  assign empty         = empty_q;
  assign full          = full_q;

endmodule

// File: tb/tb_systolic_deskew_collector.sv
// Directed bench for systolic_deskew_collector: staircase rows are built from
// a per-cycle schedule, outputs are recorded per cycle, then compared against
// hand-derived expectations.
module tb_systolic_deskew_collector;
  localparam int N     = 32;
  localparam int L     = 5;
  localparam int W     = N * L;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int SL    = 64;

  logic          clk;
  logic          clr;
  logic [CW-1:0] rows_out;
  logic          skew_err, ovf_err, empty, full;

  systolic_deskew_collector_if #(.N(N), .L(L)) bus ();

  systolic_deskew_collector #(.N(N), .L(L), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (bus.slave),
    .rows_out (rows_out),
    .skew_err (skew_err),
    .ovf_err  (ovf_err),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [L-1:0] sched_v [SL];
  logic [W-1:0] sched_d [SL];
  logic         sched_r [SL];
  logic         o_v     [SL];
  logic [W-1:0] o_d     [SL];
  logic         o_full  [SL];
  logic         o_empty [SL];
  logic         o_skew  [SL];
  logic         o_ovf   [SL];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] row(input int base);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[k*N +: N] = N'(base + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched(input logic rdy);
    for (int c = 0; c < SL; c++) begin
      sched_v[c] = '0;
      sched_d[c] = '0;
      sched_r[c] = rdy;
    end
  endtask

  task automatic set_ready(input int from, input int upto, input logic rdy);
    for (int c = from; c <= upto; c++) sched_r[c] = rdy;
  endtask

  // Row whose lane 0 arrives in cycle 'start'; lane k arrives k cycles later.
  task automatic add_row(input int start, input int base, input logic [L-1:0] mask);
    for (int k = 0; k < L; k++) begin
      if (mask[k]) begin
        sched_v[start+k][k]         = 1'b1;
        sched_d[start+k][k*N +: N]  = N'(base + k);
      end
    end
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      o_v[c]       = bus.out_valid;
      o_d[c]       = bus.out_data;
      o_full[c]    = full;
      o_empty[c]   = empty;
      o_skew[c]    = skew_err;
      o_ovf[c]     = ovf_err;
      bus.in_valid  = sched_v[c];
      bus.in_data   = sched_d[c];
      bus.out_ready = sched_r[c];
      tick();
    end
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    clr           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (ncyc) tick();
    clr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk1 ($sformatf("%s_out_valid", tag), bus.out_valid, 1'b0);
    chkw ($sformatf("%s_out_data", tag),  bus.out_data,  '0);
    chk16($sformatf("%s_rows_out", tag),  rows_out,      '0);
    chk1 ($sformatf("%s_skew_err", tag),  skew_err,      1'b0);
    chk1 ($sformatf("%s_ovf_err", tag),   ovf_err,       1'b0);
    chk1 ($sformatf("%s_empty", tag),     empty,         1'b1);
    chk1 ($sformatf("%s_full", tag),      full,          1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clr           = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    do_reset(2);
    check_reset("rst0");

    // Single row, lanes 0x10..0x14: emitted only in cycle 5.
    clear_sched(1'b1);
    add_row(0, 'h10, '1);
    run(10);
    for (int c = 0; c < 10; c++) chk1($sformatf("t1_valid_c%0d", c), o_v[c], c == 5);
    chkw ("t1_data",    o_d[5],   row('h10));
    chk16("t1_rows",    rows_out, 16'd1);
    chk1 ("t1_skew",    skew_err, 1'b0);
    chk1 ("t1_ovf",     ovf_err,  1'b0);
    chk1 ("t1_empty",   empty,    1'b1);

    do_reset(1);
    check_reset("rst1");

    // Nine back-to-back rows: out_valid in cycles 5..13, in order.
    clear_sched(1'b1);
    for (int i = 0; i < 9; i++) add_row(i, i * 5, '1);
    run(20);
    for (int c = 0; c < 20; c++) chk1($sformatf("t2_valid_c%0d", c), o_v[c], (c >= 5) && (c <= 13));
    for (int i = 0; i < 9; i++) chkw($sformatf("t2_data_r%0d", i), o_d[5+i], row(i * 5));
    chk16("t2_rows",  rows_out, 16'd9);
    chk1 ("t2_empty", empty,    1'b1);
    chk1 ("t2_skew",  skew_err, 1'b0);

    do_reset(1);
    check_reset("rst2");

    // Backpressure: six rows into a 4-deep FIFO, rows 4 and 5 dropped.
    clear_sched(1'b0);
    set_ready(12, SL - 1, 1'b1);
    for (int i = 0; i < 6; i++) add_row(i, 'h40 + i * 5, '1);
    run(20);
    chk1("t3_full_c7",  o_full[7], 1'b0);
    chk1("t3_full_c8",  o_full[8], 1'b1);
    chk1("t3_ovf_c8",   o_ovf[8],  1'b0);
    chk1("t3_ovf_c9",   o_ovf[9],  1'b1);
    chk1("t3_valid_c11", o_v[11],  1'b1);
    chkw("t3_hold_c11", o_d[11],   row('h40));
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("t3_valid_c%0d", 12 + i), o_v[12+i], 1'b1);
      chkw($sformatf("t3_data_r%0d", i), o_d[12+i], row('h40 + i * 5));
    end
    chk1 ("t3_full_c13",  o_full[13], 1'b0);
    chk1 ("t3_valid_c16", o_v[16],    1'b0);
    chk16("t3_rows",  rows_out, 16'd4);
    chk1 ("t3_empty", empty,    1'b1);
    chk1 ("t3_ovf",   ovf_err,  1'b1);

    do_reset(1);
    check_reset("rst3");

    // Full FIFO with a pop in the same cycle a fifth row completes.
    clear_sched(1'b0);
    set_ready(8, 8, 1'b1);
    set_ready(12, SL - 1, 1'b1);
    for (int i = 0; i < 5; i++) add_row(i, 'hC0 + i * 5, '1);
    run(20);
    chk1("t5_full_c8",  o_full[8], 1'b1);
    chk1("t5_full_c9",  o_full[9], 1'b1);
    chk1("t5_ovf_c9",   o_ovf[9],  1'b0);
    chkw("t5_head_c9",  o_d[9],    row('hC5));
    for (int i = 0; i < 4; i++) chkw($sformatf("t5_data_r%0d", i + 1), o_d[12+i], row('hC5 + i * 5));
    chk1 ("t5_valid_c16", o_v[16], 1'b0);
    chk16("t5_rows", rows_out, 16'd5);
    chk1 ("t5_ovf",  ovf_err,  1'b0);

    do_reset(1);
    check_reset("rst4");

    // Skew violation: middle row loses lane 2, neighbours pass intact.
    clear_sched(1'b1);
    add_row(0, 'h80, '1);
    add_row(1, 'h85, 5'b11011);
    add_row(2, 'h8A, '1);
    run(12);
    chk1("t4_valid_c5", o_v[5], 1'b1);
    chkw("t4_data_c5",  o_d[5], row('h80));
    chk1("t4_valid_c6", o_v[6], 1'b0);
    chk1("t4_valid_c7", o_v[7], 1'b1);
    chkw("t4_data_c7",  o_d[7], row('h8A));
    chk1("t4_valid_c8", o_v[8], 1'b0);
    chk1("t4_skew_c5",  o_skew[5], 1'b0);
    chk1("t4_skew_c6",  o_skew[6], 1'b1);
    chk16("t4_rows", rows_out, 16'd2);
    chk1 ("t4_ovf",  ovf_err,  1'b0);

    // Reset mid-stream while three rows are partly in flight.
    clear_sched(1'b1);
    for (int i = 0; i < 3; i++) add_row(i, 'hE0 + i * 5, '1);
    run(4);
    do_reset(1);
    check_reset("t6_rst");
    clear_sched(1'b1);
    add_row(0, 'h5A, '1);
    run(10);
    for (int c = 0; c < 10; c++) chk1($sformatf("t6_valid_c%0d", c), o_v[c], c == 5);
    chkw ("t6_data", o_d[5],   row('h5A));
    chk16("t6_rows", rows_out, 16'd1);
    chk1 ("t6_skew", skew_err, 1'b0);
    chk1 ("t6_ovf",  ovf_err,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
